// File: rtl/hpm_unit_pkg.sv
// Shared definitions for the hardware performance monitor: mhpmevent layout,
// CSR address constants and a helper that sanitises mhpmevent writes.
package hpm_unit_pkg;

   localparam int HpmSelW      = 8;
   localparam int HpmOfBit     = 31;
   localparam int HpmOfMaskBit = 30;

   // mhpmevent CSR image; rsvd is always held at zero so reads return 0 there
   typedef struct packed {
      logic               of;
      logic               ofmask;
      logic [21:0]        rsvd;
      logic [HpmSelW-1:0] sel;
   } mhpmevent_t;

   localparam logic [11:0] CsrMcycle        = 12'hB00;
   localparam logic [11:0] CsrMcycleh       = 12'hB80;
   localparam logic [11:0] CsrMinstret      = 12'hB02;
   localparam logic [11:0] CsrMcountinhibit = 12'h320;

   // Keep only the implemented mhpmevent fields of a CSR write value
   function automatic mhpmevent_t mhpmevent_from_wdata(input logic [31:0] w);
      mhpmevent_t e;
      e        = '0;
      e.of     = w[HpmOfBit];
      e.ofmask = w[HpmOfMaskBit];
      e.sel    = w[HpmSelW-1:0];
      return e;
   endfunction

endpackage

// File: rtl/hpm_counter.sv
// One performance counter of CntWidth bits with split 32-bit CSR write ports
// and a one-cycle pulse when an increment carries it from all-ones to zero.
module hpm_counter #(
   parameter int CntWidth = 64
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                incr_en,
   input  logic                we_lo,
   input  logic                we_hi,
   input  logic [31:0]         wdata,
   output logic [CntWidth-1:0] value,
   output logic                wrap_pulse
);

   logic [CntWidth-1:0] value_q, value_d;

   // Next value: a CSR write replaces its half and suppresses the increment
   always_comb begin
      value_d = value_q;
      if (we_lo) begin
         value_d[31:0] = wdata;
      end else if (we_hi) begin
         value_d[CntWidth-1:32] = wdata[CntWidth-33:0];
      end else if (incr_en) begin
         value_d = value_q + CntWidth'(1);
      end
   end

   // Counter register
   always_ff @(posedge clock) begin
      if (reset) begin
         value_q <= '0;
      end else begin
         value_q <= value_d;
      end
   end

   assign value      = value_q;
   assign wrap_pulse = incr_en & ~we_lo & ~we_hi & (&value_q);

endmodule

// File: rtl/hpm_unit.sv
// Performance monitor: mcycle, minstret and NumHpm programmable counters with
// event selectors, mcountinhibit, per-counter overflow flags and an irq.
module hpm_unit
   import hpm_unit_pkg::*;
#(
   parameter int NumHpm    = 8,
   parameter int NumEvents = 16,
   parameter int CntWidth  = 64
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 instret,
   input  logic [NumEvents-1:0] events,
   input  logic [11:0]          csr_addr,
   input  logic                 csr_we,
   input  logic [31:0]          csr_wdata,
   output logic [31:0]          csr_rdata,
   output logic                 csr_hit,
   output logic                 ovf_irq
);

   localparam logic [31:0] InhibitMask = 32'h5 | (((32'h1 << NumHpm) - 32'h1) << 3);

   // Read one 32-bit half of a counter
   function automatic logic [31:0] cnt_rd(input logic [CntWidth-1:0] v, input logic hi);
      if (hi) return 32'(v >> 32);
      return v[31:0];
   endfunction

   // Address decode: windows share bits [11:5], index is [4:0]
   logic [4:0] csr_idx;
   logic       cnt_lo_win, cnt_hi_win, cnt_win, evt_win, hpm_idx_ok;
   logic       is_cycle, is_instret, is_inhibit;

   assign csr_idx    = csr_addr[4:0];
   assign cnt_lo_win = (csr_addr[11:5] == CsrMcycle[11:5]);
   assign cnt_hi_win = (csr_addr[11:5] == CsrMcycleh[11:5]);
   assign cnt_win    = cnt_lo_win | cnt_hi_win;
   assign evt_win    = (csr_addr[11:5] == CsrMcountinhibit[11:5]);
   assign hpm_idx_ok = ({1'b0, csr_idx} >= 6'd3) && ({1'b0, csr_idx} < 6'(NumHpm + 3));
   assign is_cycle   = (csr_idx == CsrMcycle[4:0]);
   assign is_instret = (csr_idx == CsrMinstret[4:0]);
   assign is_inhibit = (csr_idx == CsrMcountinhibit[4:0]);
   assign csr_hit    = (cnt_win & (is_cycle | is_instret | hpm_idx_ok)) |
                       (evt_win & (is_inhibit | hpm_idx_ok));

   // Event k+1 lives at bit k+1; bit 0 (sel=0) and out-of-range selectors read 0
   logic [255:0] ev_ext;
   assign ev_ext = 256'({events, 1'b0});

   logic [31:0] inhibit_q;

   // mcountinhibit: only implemented counter bits are stored
   always_ff @(posedge clock) begin
      if (reset) begin
         inhibit_q <= '0;
      end else if (csr_we && evt_win && is_inhibit) begin
         inhibit_q <= csr_wdata & InhibitMask;
      end
   end

   logic [CntWidth-1:0] mcycle_val, minstret_val;
   logic                unused_fixed_wrap;
   logic                mcycle_wrap, minstret_wrap;

   hpm_counter #(.CntWidth(CntWidth)) u_mcycle (
      .clock      (clock),
      .reset      (reset),
      .incr_en    (~inhibit_q[0]),
      .we_lo      (csr_we & cnt_lo_win & is_cycle),
      .we_hi      (csr_we & cnt_hi_win & is_cycle),
      .wdata      (csr_wdata),
      .value      (mcycle_val),
      .wrap_pulse (mcycle_wrap)
   );

   hpm_counter #(.CntWidth(CntWidth)) u_minstret (
      .clock      (clock),
      .reset      (reset),
      .incr_en    (instret & ~inhibit_q[2]),
      .we_lo      (csr_we & cnt_lo_win & is_instret),
      .we_hi      (csr_we & cnt_hi_win & is_instret),
      .wdata      (csr_wdata),
      .value      (minstret_val),
      .wrap_pulse (minstret_wrap)
   );

   // mcycle and minstret wrap silently
   assign unused_fixed_wrap = mcycle_wrap ^ minstret_wrap;

   logic [31:0]       rd_chain [NumHpm+1];
   logic [NumHpm-1:0] irq_terms;
   assign rd_chain[0] = '0;

   for (genvar i = 0; i < NumHpm; i++) begin : g_hpm
      localparam logic [4:0] Idx = 5'(i + 3);
      logic                sel_me, ev_act, wrap;
      logic [CntWidth-1:0] val;
      mhpmevent_t          evt_q;

      assign sel_me = (csr_idx == Idx);
      assign ev_act = ev_ext[evt_q.sel];

      hpm_counter #(.CntWidth(CntWidth)) u_cnt (
         .clock      (clock),
         .reset      (reset),
         .incr_en    (ev_act & ~inhibit_q[i+3]),
         .we_lo      (csr_we & cnt_lo_win & sel_me),
         .we_hi      (csr_we & cnt_hi_win & sel_me),
         .wdata      (csr_wdata),
         .value      (val),
         .wrap_pulse (wrap)
      );

      // mhpmevent: a CSR write (including its OF bit) beats a same-cycle wrap
      always_ff @(posedge clock) begin
         if (reset) begin
            evt_q <= '0;
         end else if (csr_we && evt_win && sel_me) begin
            evt_q <= mhpmevent_from_wdata(csr_wdata);
         end else if (wrap) begin
            evt_q.of <= 1'b1;
         end
      end

      assign rd_chain[i+1] = rd_chain[i] |
                             ((cnt_win && sel_me) ? cnt_rd(val, cnt_hi_win) : 32'h0) |
                             ((evt_win && sel_me) ? 32'(evt_q) : 32'h0);
      assign irq_terms[i]  = evt_q.of & ~evt_q.ofmask;
   end

   // Read mux; zero while in reset so the reset cycle already reads cleared state
   always_comb begin
      csr_rdata = '0;
      if (!reset && csr_hit) begin
         if (cnt_win && is_cycle) begin
            csr_rdata = cnt_rd(mcycle_val, cnt_hi_win);
         end else if (cnt_win && is_instret) begin
            csr_rdata = cnt_rd(minstret_val, cnt_hi_win);
         end else if (evt_win && is_inhibit) begin
            csr_rdata = inhibit_q;
         end else begin
            csr_rdata = rd_chain[NumHpm];
         end
      end
   end

   logic irq_q;

   // Interrupt request registered from the stored OF/OFMASK state
   always_ff @(posedge clock) begin
      if (reset) begin
         irq_q <= 1'b0;
      end else begin
         irq_q <= |irq_terms;
      end
   end

   assign ovf_irq = irq_q;

endmodule

// File: tb/tb_hpm_unit.sv
// Directed bench for hpm_unit: a 64-bit and a 40-bit instance share stimulus;
// expected values are queued at issue time and checked by a negedge monitor.
module tb_hpm_unit;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        instret = 1'b0;
   logic [15:0] events = '0;
   logic [11:0] csr_addr = '0;
   logic        csr_we = 1'b0;
   logic [31:0] csr_wdata = '0;

   logic [31:0] rdata64, rdata40;
   logic        hit64, hit40, irq64, irq40;

   int checks = 0;
   int errors = 0;

   logic [31:0] exp_q[$];
   int          kind_q[$];
   string       name_q[$];
   logic        mon_req = 1'b0;

   logic [31:0] mon_got, mon_exp;
   int          mon_kind;
   string       mon_name;

   hpm_unit #(.NumHpm(8), .NumEvents(16), .CntWidth(64)) dut64 (
      .clock     (clock),
      .reset     (reset),
      .instret   (instret),
      .events    (events),
      .csr_addr  (csr_addr),
      .csr_we    (csr_we),
      .csr_wdata (csr_wdata),
      .csr_rdata (rdata64),
      .csr_hit   (hit64),
      .ovf_irq   (irq64)
   );

   hpm_unit #(.NumHpm(8), .NumEvents(16), .CntWidth(40)) dut40 (
      .clock     (clock),
      .reset     (reset),
      .instret   (instret),
      .events    (events),
      .csr_addr  (csr_addr),
      .csr_we    (csr_we),
      .csr_wdata (csr_wdata),
      .csr_rdata (rdata40),
      .csr_hit   (hit40),
      .ovf_irq   (irq40)
   );

   // Clock
   always #5 clock = ~clock;

   // Advance to the next cycle and drop single-cycle strobes
   task automatic cyc();
      @(posedge clock);
      #1;
      csr_we  = 1'b0;
      events  = '0;
      mon_req = 1'b0;
   endtask

   task automatic wr(input logic [11:0] a, input logic [31:0] d);
      cyc();
      csr_addr  = a;
      csr_we    = 1'b1;
      csr_wdata = d;
   endtask

   task automatic pulse(input logic [15:0] ev);
      cyc();
      events = ev;
   endtask

   // Queue an expectation for the current cycle
   // kinds: 0 rdata64, 1 irq64, 2 hit64, 3 rdata40, 4 irq40, 5 hit40
   task automatic exp_now(input int k, input logic [31:0] e, input string n);
      exp_q.push_back(e);
      kind_q.push_back(k);
      name_q.push_back(n);
      mon_req = 1'b1;
   endtask

   task automatic chk(input int k, input logic [11:0] a, input logic [31:0] e, input string n);
      cyc();
      csr_addr = a;
      exp_now(k, e, n);
   endtask

   // Monitor / scoreboard
   always @(negedge clock) begin
      if (mon_req) begin
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL monitor: output presented with empty expected queue");
         end else begin
            mon_exp  = exp_q.pop_front();
            mon_kind = kind_q.pop_front();
            mon_name = name_q.pop_front();
            case (mon_kind)
               0:       mon_got = rdata64;
               1:       mon_got = {31'b0, irq64};
               2:       mon_got = {31'b0, hit64};
               3:       mon_got = rdata40;
               4:       mon_got = {31'b0, irq40};
               5:       mon_got = {31'b0, hit40};
               default: mon_got = 'x;
            endcase
            checks++;
            if (mon_got !== mon_exp) begin
               errors++;
               $display("FAIL %s: got 0x%08h expected 0x%08h", mon_name, mon_got, mon_exp);
            end
         end
      end
   end

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   // Stimulus
   initial begin
      cyc();
      csr_addr = 12'hB00;
      exp_now(0, 32'h0, "rst_mcycle");
      cyc();
      reset = 1'b0;
      repeat (9) cyc();
      chk(0, 12'hB00, 32'd10, "idle_mcycle");
      chk(0, 12'hB02, 32'd0, "idle_minstret");
      chk(0, 12'hB03, 32'd0, "idle_hpm3");
      chk(0, 12'hB0A, 32'd0, "idle_hpm10");
      chk(1, 12'hB00, 32'd0, "idle_irq");
      chk(2, 12'hB0B, 32'd0, "hit_hpm11");
      chk(2, 12'hB01, 32'd0, "hit_time");
      chk(2, 12'h321, 32'd0, "hit_evt1");
      chk(2, 12'h323, 32'd1, "hit_evt3");
      chk(5, 12'hB8A, 32'd1, "hit40_hpm10h");
      chk(0, 12'hB0B, 32'd0, "rd_unimpl");

      // Event selection
      wr(12'h324, 32'd3);
      wr(12'h325, 32'd200);
      wr(12'h326, 32'd16);
      repeat (5) pulse(16'h0004);
      repeat (2) pulse(16'h0002);
      repeat (2) pulse(16'h8000);
      pulse(16'hFFFF);
      chk(0, 12'hB04, 32'd6, "evt_hpm4");
      chk(0, 12'hB03, 32'd0, "evt_hpm3");
      chk(0, 12'hB05, 32'd0, "evt_sel_oor");
      chk(0, 12'hB06, 32'd3, "evt_sel16");
      chk(0, 12'h325, 32'h000000C8, "evt_rd_oor");
      chk(0, 12'h326, 32'h00000010, "evt_rd_sel16");
      wr(12'h324, 32'd1);
      events = 16'h0004;
      pulse(16'h0004);
      pulse(16'h0001);
      chk(0, 12'hB04, 32'd8, "sel_change");
      chk(0, 12'hB84, 32'd0, "hpm4_high");

      // Write beats same-cycle increment
      wr(12'h325, 32'd2);
      wr(12'hB05, 32'd100);
      events = 16'h0002;
      chk(0, 12'hB05, 32'd100, "wr_wins");
      pulse(16'h0002);
      chk(0, 12'hB05, 32'd101, "after_wr");

      // Overflow on counter 3
      wr(12'h323, 32'hFFFFFFFF);
      chk(0, 12'h323, 32'hC00000FF, "evt_mask_rd");
      wr(12'h323, 32'h00000001);
      wr(12'hB03, 32'hFFFFFFFF);
      wr(12'hB83, 32'hFFFFFFFF);
      chk(0, 12'hB83, 32'hFFFFFFFF, "hpm3_high");
      chk(3, 12'hB83, 32'h000000FF, "hpm3_high40");
      pulse(16'h0001);
      chk(1, 12'hB00, 32'd0, "irq_not_yet");
      chk(1, 12'hB00, 32'd1, "irq_raised");
      chk(0, 12'h323, 32'h80000001, "of_set");
      chk(0, 12'hB03, 32'd0, "wrap_lo");
      chk(0, 12'hB83, 32'd0, "wrap_hi");
      chk(4, 12'hB00, 32'd1, "irq40_raised");
      wr(12'h323, 32'hC0000001);
      chk(1, 12'hB00, 32'd1, "mask_lag");
      chk(1, 12'hB00, 32'd0, "mask_drop");
      wr(12'h323, 32'h80000001);
      chk(1, 12'hB00, 32'd0, "unmask_lag");
      chk(1, 12'hB00, 32'd1, "unmask_raise");
      wr(12'h323, 32'h00000001);
      chk(1, 12'hB00, 32'd1, "ofclr_lag");
      chk(1, 12'hB00, 32'd0, "ofclr_drop");
      chk(0, 12'h323, 32'h00000001, "ofclr_rd");

      // mhpmevent write vs same-cycle overflow
      wr(12'hB03, 32'hFFFFFFFF);
      wr(12'hB83, 32'hFFFFFFFF);
      wr(12'h323, 32'h00000001);
      events = 16'h0001;
      chk(0, 12'h323, 32'h00000001, "of_write_wins");
      chk(0, 12'hB03, 32'd0, "of_write_cnt");
      chk(1, 12'hB00, 32'd0, "of_write_irq");

      // Counter write vs same-cycle wrap: no OF
      wr(12'hB03, 32'hFFFFFFFF);
      wr(12'hB83, 32'hFFFFFFFF);
      wr(12'hB03, 32'd5);
      events = 16'h0001;
      chk(0, 12'hB03, 32'd5, "nowrap_lo");
      chk(0, 12'h323, 32'h00000001, "nowrap_of");
      chk(0, 12'hB83, 32'hFFFFFFFF, "nowrap_hi");

      // mcountinhibit
      wr(12'h320, 32'hFFFFFFFF);
      chk(0, 12'h320, 32'h000007FD, "inhibit_mask");
      wr(12'h320, 32'h0);
      wr(12'hB00, 32'd1000);
      wr(12'hB02, 32'd500);
      instret = 1'b1;
      wr(12'h320, 32'h5);
      chk(0, 12'hB00, 32'd1002, "inh_mcycle");
      chk(0, 12'hB02, 32'd501, "inh_minstret");
      chk(0, 12'hB00, 32'd1002, "inh_frozen");
      wr(12'h320, 32'h0);
      exp_now(0, 32'h5, "inh_rd_old");
      chk(0, 12'hB00, 32'd1002, "resume_lag");
      chk(0, 12'hB02, 32'd502, "resume_minstret");
      chk(0, 12'hB00, 32'd1004, "resume_mcycle");
      instret = 1'b0;

      // 40-bit width on counter 7
      wr(12'h327, 32'h00000001);
      wr(12'hB87, 32'hFFFFFFFF);
      chk(3, 12'hB87, 32'h000000FF, "w40_high");
      chk(0, 12'hB87, 32'hFFFFFFFF, "w64_high");
      wr(12'hB87, 32'h000000FF);
      wr(12'hB07, 32'hFFFFFFFF);
      pulse(16'h0001);
      chk(3, 12'hB07, 32'd0, "w40_wrap_lo");
      chk(3, 12'hB87, 32'd0, "w40_wrap_hi");
      chk(0, 12'hB87, 32'h00000100, "w64_carry_hi");
      chk(0, 12'hB07, 32'd0, "w64_carry_lo");
      chk(3, 12'h327, 32'h80000001, "w40_of");
      chk(0, 12'h327, 32'h00000001, "w64_no_of");
      chk(4, 12'hB00, 32'd1, "w40_irq");
      chk(1, 12'hB00, 32'd0, "w64_irq");

      // Mid-run reset with activity
      cyc();
      reset   = 1'b1;
      events  = 16'hFFFF;
      instret = 1'b1;
      csr_addr = 12'hB04;
      exp_now(0, 32'h0, "rst_cycle_rd");
      cyc();
      reset   = 1'b0;
      instret = 1'b0;
      csr_addr = 12'hB00;
      exp_now(0, 32'h0, "rst2_mcycle");
      chk(0, 12'hB04, 32'd0, "rst2_hpm4");
      chk(3, 12'h327, 32'd0, "rst2_evt7");
      chk(4, 12'hB00, 32'd0, "rst2_irq40");
      chk(0, 12'h320, 32'd0, "rst2_inhibit");

      cyc();
      cyc();
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
